// File: rtl/pwm_pkg.sv
// Shared PWM definitions: dead-time FSM state encoding and default widths
// used by the PWM generator and the dead-time inserter.
package pwm_pkg;

    localparam int PWM_DEAD_W_DEF = 4;
    localparam int PWM_CNT_W_DEF  = 4;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_LS    = 3'd1,
        S_DT_H  = 3'd2,
        S_HS    = 3'd3,
`ifdef PWM_DEADTIME_FAULT_EN
        S_DT_L  = 3'd4,
        S_FAULT = 3'd5
`else
        S_DT_L  = 3'd4
`endif
    } pwm_dt_state_t;

    function automatic logic is_dead_state(input pwm_dt_state_t s);
        return (s == S_DT_H) || (s == S_DT_L);
    endfunction

endpackage

// File: rtl/pwm_dt_timer.sv
// Loadable down-counter for the dead interval; holds at zero instead of wrapping.
module pwm_dt_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: turns a single-ended PWM stream into a non-overlapping HS/LS pair.
// Optional latching fault shutdown is built in when PWM_DEADTIME_FAULT_EN is defined.
//
// state   | meaning
// S_OFF   | after reset, both drives off
// S_LS    | low side on
// S_DT_H  | dead interval heading towards high side
// S_HS    | high side on
// S_DT_L  | dead interval heading towards low side
// S_FAULT | fault latched, both off until reset (fault build only)
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEAD_W = PWM_DEAD_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pwm_in,
    input  logic [DEAD_W-1:0] i_dead,
`ifdef PWM_DEADTIME_FAULT_EN
    input  logic              i_fault,
    output logic              o_fault_latched,
`endif
    output logic              o_hs,
    output logic              o_ls,
    output logic              o_busy
);

    pwm_dt_state_t     r_state;
    pwm_dt_state_t     w_next;
    logic              r_pwm_q;
    logic              w_load;
    logic              w_done;
    logic [DEAD_W-1:0] w_load_val;

    // A dead time of 0 behaves as 1, so the counter preload is max(DEAD,1)-1.
    assign w_load_val = (i_dead == '0) ? '0 : i_dead - 1'b1;

    pwm_dt_timer #(
        .W (DEAD_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_OFF: begin
                w_next = r_pwm_q ? S_DT_H : S_DT_L;
                w_load = 1'b1;
            end
            S_LS: begin
                if (r_pwm_q) begin
                    w_next = S_DT_H;
                    w_load = 1'b1;
                end
            end
            S_HS: begin
                if (!r_pwm_q) begin
                    w_next = S_DT_L;
                    w_load = 1'b1;
                end
            end
            S_DT_H, S_DT_L: begin
                // Short pulses/gaps are absorbed: the side is chosen from pwm_q at expiry.
                if (w_done) begin
                    w_next = r_pwm_q ? S_HS : S_LS;
                end
            end
`ifdef PWM_DEADTIME_FAULT_EN
            S_FAULT: w_next = S_FAULT;
`endif
            default: w_next = S_OFF;
        endcase
`ifdef PWM_DEADTIME_FAULT_EN
        if (i_fault) begin
            w_next = S_FAULT;
            w_load = 1'b0;
        end
`endif
    end

    // Outputs decode the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= S_OFF;
            r_pwm_q         <= 1'b0;
            o_hs            <= 1'b0;
            o_ls            <= 1'b0;
            o_busy          <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
            o_fault_latched <= 1'b0;
`endif
        end else begin
            r_state         <= w_next;
            r_pwm_q         <= i_pwm_in;
            o_hs            <= (w_next == S_HS);
            o_ls            <= (w_next == S_LS);
            o_busy          <= is_dead_state(w_next);
`ifdef PWM_DEADTIME_FAULT_EN
            o_fault_latched <= o_fault_latched | (w_next == S_FAULT);
`endif
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime with hand-computed expectations; covers the
// PWM_DEADTIME_FAULT_EN build when that macro is defined.
module tb_pwm_deadtime;
    import pwm_pkg::*;

    localparam int DW = PWM_DEAD_W_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm_in = 1'b0;
    logic [DW-1:0] dead = 3;
    logic          hs, ls, busy;
`ifdef PWM_DEADTIME_FAULT_EN
    logic          fault = 1'b0;
    logic          fault_latched;
`endif

    logic [PWM_CNT_W_DEF-1:0] gcnt = '0;
    logic [PWM_CNT_W_DEF-1:0] gduty = '0;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    pwm_deadtime #(.DEAD_W(DW)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pwm_in        (pwm_in),
        .i_dead          (dead),
`ifdef PWM_DEADTIME_FAULT_EN
        .i_fault         (fault),
        .o_fault_latched (fault_latched),
`endif
        .o_hs            (hs),
        .o_ls            (ls),
        .o_busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input int h, input int l, input int b);
        chk({tag, ".hs"}, 32'(hs), 32'(h));
        chk({tag, ".ls"}, 32'(ls), 32'(l));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    // Stand-in for the PWM generator: output high while counter < duty.
    task automatic gen_tick();
        pwm_in = (gcnt < gduty);
        tick();
        gcnt = gcnt + 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) chk("overlap", 32'(hs & ls), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lscnt, hsseen, hslow, lson, busycnt;
        bit  lvl;

        // Reset and startup, DEAD=3: 1 cycle S_OFF + 3 dead cycles, then LS.
        rst = 1'b1; pwm_in = 1'b0; dead = 3;
        tick(); tick();
        mon_en = 1'b1;
        expect3("reset", 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect3("startup_dt", 0, 0, 1);
        end
        tick(); expect3("startup_ls", 0, 1, 0);

        // Rising edge with DEAD=3.
        pwm_in = 1'b1;
        tick(); expect3("rise_k", 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); expect3("rise_dt", 0, 0, 1);
        end
        tick(); expect3("rise_hs", 1, 0, 0);

        // Falling edge; DEAD changes mid-interval and must not affect it.
        pwm_in = 1'b0;
        tick(); expect3("fall_k", 1, 0, 0);
        tick(); expect3("fall_dt", 0, 0, 1);
        dead = 7;
        tick(); expect3("fall_dt_hold", 0, 0, 1);
        tick(); expect3("fall_dt_hold", 0, 0, 1);
        tick(); expect3("fall_ls", 0, 1, 0);

        // DEAD=0 acts as 1: single-cycle gap on each transition.
        dead = 0;
        for (int t = 0; t < 4; t++) begin
            lvl = !pwm_in;
            pwm_in = lvl;
            tick(); expect3("dt0_k", int'(!lvl), int'(lvl), 0);
            tick(); expect3("dt0_gap", 0, 0, 1);
            tick(); expect3("dt0_on", int'(lvl), int'(!lvl), 0);
            repeat (5) tick();
        end

        // Short 3-cycle high pulse with DEAD=5 is absorbed.
        dead = 5;
        lscnt = 0; hsseen = 0;
        for (int i = 0; i < 12; i++) begin
            pwm_in = (i < 3);
            tick();
            if (!ls) lscnt++;
            if (hs) hsseen = 1;
        end
        chk("short_ls_off_cycles", 32'(lscnt), 32'd5);
        chk("short_hs_seen", 32'(hsseen), 32'd0);
        chk("short_ls_back", 32'(ls), 32'd1);

        // Generator at full scale (duty 15/16), DEAD=2: 1-cycle low gaps absorbed.
        dead = 2; gduty = 4'hF; gcnt = '0;
        repeat (32) gen_tick();
        hslow = 0; lson = 0; busycnt = 0;
        for (int i = 0; i < 64; i++) begin
            gen_tick();
            if (!hs) hslow++;
            if (ls) lson++;
            if (busy) busycnt++;
        end
        chk("fs_hs_low_cycles", 32'(hslow), 32'd8);
        chk("fs_ls_on_cycles", 32'(lson), 32'd0);
        chk("fs_busy_cycles", 32'(busycnt), 32'd8);

        // Reset inside a dead interval.
        for (int i = 0; i < 40 && !busy; i++) gen_tick();
        chk("find_dead_interval", 32'(busy), 32'd1);
        rst = 1'b1; pwm_in = 1'b1;
        tick(); expect3("mid_rst", 0, 0, 0);
        rst = 1'b0;
        tick(); expect3("rst_restart_dt", 0, 0, 1);
        tick(); expect3("rst_restart_dt", 0, 0, 1);
        tick(); expect3("rst_restart_hs", 1, 0, 0);

`ifdef PWM_DEADTIME_FAULT_EN
        chk("fault_latched_idle", 32'(fault_latched), 32'd0);
        fault = 1'b1;
        tick(); expect3("fault", 0, 0, 0);
        chk("fault_latched", 32'(fault_latched), 32'd1);
        fault = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pwm_in = i[0];
            tick(); expect3("fault_hold", 0, 0, 0);
            chk("fault_latched_hold", 32'(fault_latched), 32'd1);
        end
        rst = 1'b1;
        tick();
        chk("fault_cleared", 32'(fault_latched), 32'd0);
        rst = 1'b0;
`endif

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
